// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand select, MEM/WB forwarding and load-use stall
// Optional stall counter output enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [3:0]    id_alu_op,
    input  logic [RW-1:0] id_rs_addr,
    input  logic [RW-1:0] id_rt_addr,
    input  logic [RW-1:0] id_rd_addr,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_sa,
    input  logic          id_use_sa,
    input  logic          id_use_imm,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          flush,
    input  logic          stall_ext,
    input  logic          mem_reg_write,
    input  logic [RW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_alu_res,
    input  logic          wb_reg_write,
    input  logic [RW-1:0] wb_rd_addr,
    input  logic [DW-1:0] wb_data,
    output logic          id_stall,
    output logic          ex_valid,
    output logic [3:0]    ex_alu_op,
    output logic [DW-1:0] ex_opnd1,
    output logic [DW-1:0] ex_opnd2,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_rd_addr,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    logic          valid_q, valid_d;
    logic [3:0]    alu_op_q, alu_op_d;
    logic [RW-1:0] rs_addr_q, rs_addr_d;
    logic [RW-1:0] rt_addr_q, rt_addr_d;
    logic [RW-1:0] rd_addr_q, rd_addr_d;
    logic [DW-1:0] rs_data_q, rs_data_d;
    logic [DW-1:0] rt_data_q, rt_data_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [4:0]    sa_q, sa_d;
    logic          use_sa_q, use_sa_d;
    logic          use_imm_q, use_imm_d;
    logic          reg_write_q, reg_write_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;

    logic          wb_hit_rs, wb_hit_rt;
    logic          bubble;
    logic [DW-1:0] fwd_rs, fwd_rt;

    // Load-use: a load in EX whose destination the ID instruction reads.
    always_comb begin
        id_stall = 1'b0;
        if (valid_q && mem_read_q && id_valid && (rd_addr_q != '0)) begin
            if (((rd_addr_q == id_rs_addr) && !id_use_sa) || (rd_addr_q == id_rt_addr)) begin
                id_stall = 1'b1;
            end
        end
    end

    assign wb_hit_rs = wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == id_rs_addr);
    assign wb_hit_rt = wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == id_rt_addr);
    assign bubble    = flush || (!stall_ext && id_stall);

    always_comb begin
        valid_d     = valid_q;
        alu_op_d    = alu_op_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;
        rd_addr_d   = rd_addr_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm_d       = imm_q;
        sa_d        = sa_q;
        use_sa_d    = use_sa_q;
        use_imm_d   = use_imm_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        if (bubble) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else if (!stall_ext) begin
            valid_d     = id_valid;
            alu_op_d    = id_alu_op;
            rs_addr_d   = id_rs_addr;
            rt_addr_d   = id_rt_addr;
            rd_addr_d   = id_rd_addr;
            // Register file written this cycle: take the value being written.
            rs_data_d   = wb_hit_rs ? wb_data : id_rs_data;
            rt_data_d   = wb_hit_rt ? wb_data : id_rt_data;
            imm_d       = id_imm;
            sa_d        = id_sa;
            use_sa_d    = id_use_sa;
            use_imm_d   = id_use_imm;
            reg_write_d = id_reg_write && id_valid;
            mem_read_d  = id_mem_read && id_valid;
            mem_write_d = id_mem_write && id_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            alu_op_q    <= '0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rd_addr_q   <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            sa_q        <= '0;
            use_sa_q    <= 1'b0;
            use_imm_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            alu_op_q    <= alu_op_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
            rd_addr_q   <= rd_addr_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            sa_q        <= sa_d;
            use_sa_q    <= use_sa_d;
            use_imm_q   <= use_imm_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    // MEM is the younger result, so it beats WB; register 0 is hardwired.
    always_comb begin
        fwd_rs = rs_data_q;
        if (mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rs_addr_q)) begin
            fwd_rs = mem_alu_res;
        end else if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rs_addr_q)) begin
            fwd_rs = wb_data;
        end
    end

    always_comb begin
        fwd_rt = rt_data_q;
        if (mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rt_addr_q)) begin
            fwd_rt = mem_alu_res;
        end else if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rt_addr_q)) begin
            fwd_rt = wb_data;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_alu_op     = alu_op_q;
    assign ex_opnd1      = use_sa_q ? {{(DW-5){1'b0}}, sa_q} : fwd_rs;
    assign ex_opnd2      = use_imm_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_rd_addr    = rd_addr_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;

`ifdef ID_EX_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (id_stall && !stall_ext && !flush && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register that feeds the ALU (ALUop, ALUopnd1, ALUopnd2) and carries the control/destination fields on to EX/MEM.
- Selects operands:
  - shift amount or rs for operand 1;
  - immediate or rt for operand 2.
- Forwards results from MEM and WB.
- Detects load-use hazards and inserts one bubble per hazard.

Parameters:
- DW, 32, datapath width.
- RW, 5, register address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_alu_op  in  4  ALU opcode
- id_rs_addr / id_rt_addr / id_rd_addr  in  RW each  source and destination registers
- id_rs_data / id_rt_data  in  DW each  register-file read data
- id_imm  in  DW  extended immediate
- id_sa  in  5  shift amount
- id_use_sa  in  1  operand 1 = {27'b0, sa}
- id_use_imm  in  1  operand 2 = imm
- id_reg_write / id_mem_read / id_mem_write  in  1 each  control
- flush  in  1  kill the instruction entering EX
- stall_ext  in  1  global freeze
- mem_reg_write  in  1  EX/MEM stage writes a register
- mem_rd_addr  in  RW  EX/MEM destination register
- mem_alu_res  in  DW  EX/MEM ALU result
- wb_reg_write  in  1  MEM/WB stage writes a register
- wb_rd_addr  in  RW  MEM/WB destination register
- wb_data  in  DW  MEM/WB write-back data
- id_stall  out  1  load-use stall request to IF/ID (combinational)
- ex_valid  out  1  EX holds a real instruction
- ex_alu_op  out  4  to ALU
- ex_opnd1 / ex_opnd2  out  DW each  to ALU (forwarded, combinational from registers)
- ex_store_data  out  DW  forwarded rt value
- ex_rd_addr  out  RW  destination register
- ex_reg_write / ex_mem_read / ex_mem_write  out  1 each  control

Behaviour:
- Reset (async, rst_n=0): all registered fields are 0, so ex_valid=0, ex_alu_op=0, all control bits 0, and ex_opnd1/ex_opnd2/ex_store_data=0. id_stall=0 because ex_mem_read=0.
- Load-use detect (combinational):
  - id_stall=1 iff all of the following hold: ex_valid, ex_mem_read, id_valid, ex_rd_addr≠0, and ex_rd_addr==id_rs_addr (with id_use_sa=0) or ex_rd_addr==id_rt_addr.
- Per-edge update priority: flush > stall_ext > id_stall > capture.
  - flush: ex_valid←0 and all control bits←0. Flush wins over stall_ext.
  - stall_ext: all registers hold.
  - id_stall: insert a bubble (ex_valid←0, controls←0). Data fields are don't-care. The ID instruction is captured the following cycle, so the penalty is exactly 1 cycle.
  - capture: latch all id_* fields; ex_valid←id_valid. Invalid instructions have their controls forced to 0.
- Capture-time bypass:
  - If wb_reg_write and wb_rd_addr≠0 and wb_rd_addr==id_rs_addr (or id_rt_addr), latch wb_data instead of the register-file data.
  - Models write-then-read in the same cycle.
- EX-time forwarding (combinational, per source, rs and rt independently):
  - Priority 1, MEM: mem_reg_write, mem_rd_addr≠0, match → mem_alu_res.
  - Priority 2, WB: wb_reg_write, wb_rd_addr≠0, match → wb_data.
  - Otherwise the latched value.
  - Register 0 is never forwarded.
- Operand select:
  - ex_opnd1 = use_sa ? {27'b0, sa} : fwd_rs.
  - ex_opnd2 = use_imm ? imm : fwd_rt.
  - ex_store_data = fwd_rt, independent of use_imm.
- Latency: 1 cycle from ID to EX outputs.
- Reset mid-stall: state clears immediately; on release, capture resumes normally.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [15:0], reset to 0.
  - Increments on every edge where id_stall=1 and stall_ext=0 and flush=0.
  - Saturates at 16'hFFFF.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset: rst_n=0 mid-cycle with id_valid=1 → all outputs 0 asynchronously; first capture after release has ex_valid=1.
- Capture: add, rs=3 (data 5), rt=4 (data 7), no hazards → next cycle ex_alu_op=ADD, ex_opnd1=5, ex_opnd2=7.
- Forwarding:
  - mem_rd_addr=3, mem_alu_res=32'h10 and wb_rd_addr=3, wb_data=32'h20, both write-enabled → ex_opnd1=32'h10.
  - Same with mem_rd_addr=0 → 32'h20.
- Load-use: lw with rd=8 in EX; ID instruction reads rt=8 → id_stall=1 for one cycle, bubble with ex_valid=0, then capture with id_stall=0. The stall counter (if enabled) equals 1.
- Shift/imm: use_sa=1, sa=5'd31, use_imm=1, imm=32'hFFFF_FFF0, rt forwarded as 9 → ex_opnd1=32'd31, ex_opnd2=32'hFFFF_FFF0, ex_store_data=9.
- Flush vs stall: flush=1 with stall_ext=1 → ex_valid=0 next cycle. stall_ext=1 alone for 3 cycles → outputs unchanged.
